lct_l1a_sequencer: RTL and testbench

Synthesizable trigger sequencer that replays a programmed burst of LCT/L1A/DAV events into the ODMB readout path. The block generates the LCT pattern, the delayed L1A and the delayed ALCT/OTMB data-available strobes, with correct relative latencies, so the downstream DCFEB/ALCT/OTMB readout logic can be exercised in hardware without external trigger sources. It sits beside the real trigger inputs, ahead of the trigger-select mux, and is configured from the VME register block.

---
 rtl/lct_l1a_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_lct_l1a_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lct_l1a_sequencer.sv
// Trigger sequencer: replays a programmed burst of LCTs with delayed L1A and
// ALCT/OTMB data-available strobes, all timed against a free-running timebase.

module lct_ts_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);
  // DEPTH must be a power of two, at least 2, so the pointers wrap naturally
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // A push into a full queue still lands when the head leaves in the same cycle
  always_comb begin
    do_pop   = en & pop & (count_q != '0);
    do_push  = en & push & ((count_q != (AW+1)'(DEPTH)) | do_pop);
    drop     = en & push & ~do_push;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
endmodule

module lct_l1a_sequencer #(
  parameter int CNT_W      = 16,
  parameter int LAT_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] n_events,
  input  logic [CNT_W-1:0] gap,
  input  logic [7:0]       lct_mask,
  input  logic [LAT_W-1:0] l1a_lat,
  input  logic [LAT_W-1:0] alct_lat,
  input  logic [LAT_W-1:0] otmb_lat,
  output logic [7:0]       lct,
  output logic             l1a,
  output logic             alct_dav,
  output logic             otmb_dav,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] l1a_cnt,
  output logic             overflow
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ts_q, ts_d, n_q, n_d, gap_q, gap_d;
  logic [CNT_W-1:0] ev_cnt_q, ev_cnt_d, gap_cnt_q, gap_cnt_d, l1a_cnt_q, l1a_cnt_d;
  logic [LAT_W-1:0] l1a_lat_q, l1a_lat_d, alct_lat_q, alct_lat_d, otmb_lat_q, otmb_lat_d;
  logic [7:0]       mask_q, mask_d, lct_q, lct_d;
  logic             l1a_q, l1a_d, alct_q, alct_d, otmb_q, otmb_d;
  logic             busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;

  logic             start_acc, start_run, lct_issue, all_empty;
  logic [CNT_W-1:0] gap_in;
  logic [LAT_W-1:0] l1a_lat_eff;
  logic             l1a_empty, alct_empty, otmb_empty;
  logic             l1a_fire, alct_fire, otmb_fire;
  logic             l1a_drop, alct_drop, otmb_drop;
  logic [CNT_W-1:0] l1a_head, alct_head, otmb_head;

  function automatic logic [LAT_W-1:0] at_least_one(input logic [LAT_W-1:0] v);
    return (v == '0) ? LAT_W'(1) : v;
  endfunction

  function automatic logic [CNT_W-1:0] ts_plus(input logic [CNT_W-1:0] t, input logic [LAT_W-1:0] d);
    return t + {{(CNT_W-LAT_W){1'b0}}, d};
  endfunction

  // The first LCT goes out on the start edge itself, so it uses the raw inputs
  assign start_acc   = en & start & (state_q == IDLE);
  assign start_run   = start_acc & (n_events != '0);
  assign gap_in      = (gap == '0) ? CNT_W'(1) : gap;
  assign l1a_lat_eff = start_run ? at_least_one(l1a_lat) : l1a_lat_q;
  assign lct_issue   = start_run | ((state_q == RUN) & (gap_cnt_q == '0));
  assign l1a_fire    = ~l1a_empty & (l1a_head == ts_q);
  assign alct_fire   = ~alct_empty & (alct_head == ts_q);
  assign otmb_fire   = ~otmb_empty & (otmb_head == ts_q);
  assign all_empty   = l1a_empty & alct_empty & otmb_empty;

  lct_ts_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_l1a_fifo (
    .clk(clk), .rstn(rstn), .en(en), .push(lct_issue), .pop(l1a_fire),
    .push_data(ts_plus(ts_q, l1a_lat_eff)), .head(l1a_head), .empty(l1a_empty), .drop(l1a_drop));

  lct_ts_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_alct_fifo (
    .clk(clk), .rstn(rstn), .en(en), .push(l1a_fire), .pop(alct_fire),
    .push_data(ts_plus(ts_q, alct_lat_q)), .head(alct_head), .empty(alct_empty), .drop(alct_drop));

  lct_ts_fifo #(.W(CNT_W), .DEPTH(FIFO_DEPTH)) u_otmb_fifo (
    .clk(clk), .rstn(rstn), .en(en), .push(l1a_fire), .pop(otmb_fire),
    .push_data(ts_plus(ts_q, otmb_lat_q)), .head(otmb_head), .empty(otmb_empty), .drop(otmb_drop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   state_q <= IDLE;
    else if (en) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_run) state_d = (n_events == CNT_W'(1)) ? DRAIN : RUN;
      RUN:     if (lct_issue && (ev_cnt_q + 1'b1 == n_q)) state_d = DRAIN;
      DRAIN:   if (all_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ts_d       = ts_q + 1'b1;
    n_d        = n_q;
    gap_d      = gap_q;
    mask_d     = mask_q;
    l1a_lat_d  = l1a_lat_q;
    alct_lat_d = alct_lat_q;
    otmb_lat_d = otmb_lat_q;
    ev_cnt_d   = ev_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    l1a_cnt_d  = l1a_cnt_q;
    overflow_d = overflow_q;
    lct_d      = '0;
    done_d     = 1'b0;
    if (start_acc) begin
      n_d        = n_events;
      gap_d      = gap_in;
      mask_d     = lct_mask;
      l1a_lat_d  = at_least_one(l1a_lat);
      alct_lat_d = at_least_one(alct_lat);
      otmb_lat_d = at_least_one(otmb_lat);
      l1a_cnt_d  = '0;
      overflow_d = 1'b0;
      done_d     = (n_events == '0);
    end
    if (start_run) begin
      lct_d     = lct_mask;
      ev_cnt_d  = CNT_W'(1);
      gap_cnt_d = gap_in - 1'b1;
    end else if (state_q == RUN) begin
      if (gap_cnt_q == '0) begin
        lct_d     = mask_q;
        ev_cnt_d  = ev_cnt_q + 1'b1;
        gap_cnt_d = gap_q - 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q - 1'b1;
      end
    end
    if (l1a_fire) l1a_cnt_d = l1a_cnt_q + 1'b1;
    l1a_d  = l1a_fire;
    alct_d = alct_fire;
    otmb_d = otmb_fire;
    if (l1a_drop | alct_drop | otmb_drop) overflow_d = 1'b1;
    if ((state_q == DRAIN) && all_empty) done_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  // With en low everything holds, but the one-cycle strobes are forced quiet
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_q       <= '0;
      n_q        <= '0;
      gap_q      <= '0;
      mask_q     <= '0;
      l1a_lat_q  <= '0;
      alct_lat_q <= '0;
      otmb_lat_q <= '0;
      ev_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      l1a_cnt_q  <= '0;
      overflow_q <= 1'b0;
      lct_q      <= '0;
      l1a_q      <= 1'b0;
      alct_q     <= 1'b0;
      otmb_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (en) begin
      ts_q       <= ts_d;
      n_q        <= n_d;
      gap_q      <= gap_d;
      mask_q     <= mask_d;
      l1a_lat_q  <= l1a_lat_d;
      alct_lat_q <= alct_lat_d;
      otmb_lat_q <= otmb_lat_d;
      ev_cnt_q   <= ev_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      l1a_cnt_q  <= l1a_cnt_d;
      overflow_q <= overflow_d;
      lct_q      <= lct_d;
      l1a_q      <= l1a_d;
      alct_q     <= alct_d;
      otmb_q     <= otmb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end else begin
      lct_q  <= '0;
      l1a_q  <= 1'b0;
      alct_q <= 1'b0;
      otmb_q <= 1'b0;
      done_q <= 1'b0;
    end
  end

  assign lct      = lct_q;
  assign l1a      = l1a_q;
  assign alct_dav = alct_q;
  assign otmb_dav = otmb_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign l1a_cnt  = l1a_cnt_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_lct_l1a_sequencer.sv
// Scoreboard bench for lct_l1a_sequencer: expected strobe times are computed per
// burst in units of enabled clock edges and checked by an independent monitor.

module tb_lct_l1a_sequencer;
  localparam int CNT_W = 16;
  localparam int LAT_W = 12;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rstn, en, start;
  logic [CNT_W-1:0] n_events, gap;
  logic [7:0]       lct_mask;
  logic [LAT_W-1:0] l1a_lat, alct_lat, otmb_lat;
  logic [7:0]       lct;
  logic             l1a, alct_dav, otmb_dav, busy, done, overflow;
  logic [CNT_W-1:0] l1a_cnt;

  int checks = 0;
  int errors = 0;
  int act = 0;
  bit last_active = 1'b0;
  // kinds: 0 lct, 1 l1a, 2 alct_dav, 3 otmb_dav, 4 done
  int exp_t[5][$];
  int exp_v[5][$];
  string names[5] = '{"lct", "l1a", "alct_dav", "otmb_dav", "done"};

  lct_l1a_sequencer #(.CNT_W(CNT_W), .LAT_W(LAT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .n_events(n_events), .gap(gap),
    .lct_mask(lct_mask), .l1a_lat(l1a_lat), .alct_lat(alct_lat), .otmb_lat(otmb_lat),
    .lct(lct), .l1a(l1a), .alct_dav(alct_dav), .otmb_dav(otmb_dav), .busy(busy),
    .done(done), .l1a_cnt(l1a_cnt), .overflow(overflow));

  always #5 clk = ~clk;

  // Index of enabled clock edges; the reference timeline lives in these units
  always @(posedge clk) begin
    if (!rstn) last_active = 1'b0;
    else begin
      last_active = en;
      if (en) act++;
    end
  end

  // Reference model: replays the burst rules with integer queues, no wraparound
  task automatic predict(input int s, input int n, input int gap_v, input int mask,
                         input int l1a_v, input int alct_v, input int otmb_v);
    int g, cnt, ovf, last_lct;
    int lat[3];
    int q[3][$];
    bit pop0, lct_now;
    g      = (gap_v == 0) ? 1 : gap_v;
    lat[0] = (l1a_v == 0) ? 1 : l1a_v;
    lat[1] = (alct_v == 0) ? 1 : alct_v;
    lat[2] = (otmb_v == 0) ? 1 : otmb_v;
    cnt = 0;
    ovf = 0;
    if (n == 0) begin
      exp_t[4].push_back(s);
      exp_v[4].push_back(0);
      return;
    end
    last_lct = s + (n - 1) * g;
    for (int e = s; e < s + 50000; e++) begin
      if (e > last_lct && q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) begin
        exp_t[4].push_back(e);
        exp_v[4].push_back(ovf * 65536 + cnt);
        break;
      end
      lct_now = (e <= last_lct) && (((e - s) % g) == 0);
      pop0    = (q[0].size() != 0) && (q[0][0] == e);
      if (lct_now) begin
        exp_t[0].push_back(e);
        exp_v[0].push_back(mask);
      end
      if (pop0) begin
        void'(q[0].pop_front());
        cnt++;
        exp_t[1].push_back(e);
        exp_v[1].push_back(cnt);
      end
      if (lct_now) begin
        if (q[0].size() < DEPTH) q[0].push_back(e + lat[0]);
        else ovf = 1;
      end
      for (int j = 1; j < 3; j++) begin
        if (q[j].size() != 0 && q[j][0] == e) begin
          void'(q[j].pop_front());
          exp_t[j+1].push_back(e);
          exp_v[j+1].push_back(0);
        end
        if (pop0) begin
          if (q[j].size() < DEPTH) q[j].push_back(e + lat[j]);
          else ovf = 1;
        end
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes, flags late or extra strobes
  always @(negedge clk) begin
    bit fired[5];
    int val[5];
    if (rstn) begin
      fired[0] = (lct != 8'h00);
      fired[1] = l1a;
      fired[2] = alct_dav;
      fired[3] = otmb_dav;
      fired[4] = done;
      val[0] = int'(lct);
      val[1] = int'(l1a_cnt);
      val[2] = 0;
      val[3] = 0;
      val[4] = int'(overflow) * 65536 + int'(l1a_cnt);
      if (!last_active) begin
        checks++;
        if (fired[0] || fired[1] || fired[2] || fired[3] || fired[4]) begin
          errors++;
          $display("[TB] FAIL paused_quiet: got lct=%0h l1a=%0b alct=%0b otmb=%0b done=%0b, need all 0",
                   lct, l1a, alct_dav, otmb_dav, done);
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          if (fired[k]) begin
            checks++;
            if (exp_t[k].size() == 0) begin
              errors++;
              $display("[TB] FAIL %s_unexpected: got strobe val=%0d at edge %0d, need none", names[k], val[k], act);
            end else begin
              if (exp_t[k][0] != act || exp_v[k][0] != val[k]) begin
                errors++;
                $display("[TB] FAIL %s: got edge=%0d val=%0d, need edge=%0d val=%0d",
                         names[k], act, val[k], exp_t[k][0], exp_v[k][0]);
              end
              void'(exp_t[k].pop_front());
              void'(exp_v[k].pop_front());
            end
            if (k == 0 || k == 4) begin
              checks++;
              if (busy != (k == 0)) begin
                errors++;
                $display("[TB] FAIL busy_with_%s: got %0b, need %0b", names[k], busy, (k == 0));
              end
            end
          end else if (exp_t[k].size() != 0 && exp_t[k][0] <= act) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_missing: got no strobe at edge %0d, need one at edge %0d",
                     names[k], act, exp_t[k][0]);
            void'(exp_t[k].pop_front());
            void'(exp_v[k].pop_front());
          end
        end
      end
    end
  end

  task automatic clear_expect();
    for (int k = 0; k < 5; k++) begin
      exp_t[k].delete();
      exp_v[k].delete();
    end
  endtask

  task automatic check_output(input string name, input int got, input int need);
    checks++;
    if (got != need) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic apply_stimulus(input int n, input int gap_v, input int mask, input int l1a_v,
                                input int alct_v, input int otmb_v, input int pause_after,
                                input int pause_len, input bit extra_start);
    int s;
    @(posedge clk);
    #1;
    n_events = CNT_W'(n);
    gap      = CNT_W'(gap_v);
    lct_mask = 8'(mask);
    l1a_lat  = LAT_W'(l1a_v);
    alct_lat = LAT_W'(alct_v);
    otmb_lat = LAT_W'(otmb_v);
    en       = 1'b1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    s     = act;
    start = 1'b0;
    predict(s, n, gap_v, mask, l1a_v, alct_v, otmb_v);
    // Scramble the config mid-burst; the latched copy must be unaffected
    n_events = CNT_W'($urandom_range(0, 20));
    gap      = CNT_W'($urandom_range(0, 20));
    lct_mask = 8'($urandom);
    l1a_lat  = LAT_W'($urandom_range(0, 30));
    alct_lat = LAT_W'($urandom_range(0, 30));
    otmb_lat = LAT_W'($urandom_range(0, 30));
    if (extra_start) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (pause_len > 0) begin
      repeat (pause_after) @(posedge clk);
      #1;
      en = 1'b0;
      repeat (pause_len) @(posedge clk);
      #1;
      en = 1'b1;
    end
  endtask

  task automatic wait_done();
    int t;
    int left;
    t = 0;
    while (exp_t[4].size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (exp_t[4].size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done within %0d cycles, need done at edge %0d", t, exp_t[4][0]);
      clear_expect();
    end
    repeat (4) @(posedge clk);
    #1;
    left = exp_t[0].size() + exp_t[1].size() + exp_t[2].size() + exp_t[3].size();
    check_output("leftover_events", left, 0);
  endtask

  initial begin
    int n, g, a, b, c, pa, pl;
    bit ex;
    rstn = 1'b0; en = 1'b1; start = 1'b0;
    n_events = '0; gap = '0; lct_mask = '0; l1a_lat = '0; alct_lat = '0; otmb_lat = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_lct", int'(lct), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_l1a_cnt", int'(l1a_cnt), 0);
    check_output("reset_overflow", int'(overflow), 0);
    rstn = 1'b1;

    $display("[TB] basic burst with ignored restart");
    apply_stimulus(3, 10, 'h5A, 5, 2, 4, 0, 0, 1'b1);
    wait_done();

    $display("[TB] l1a queue overflow");
    apply_stimulus(10, 1, 'h33, 8, 2, 3, 0, 0, 1'b0);
    wait_done();
    check_output("overflow_sticky", int'(overflow), 1);

    $display("[TB] zero gap and latencies");
    apply_stimulus(2, 0, 'hC3, 0, 0, 0, 0, 0, 1'b0);
    wait_done();
    check_output("overflow_cleared", int'(overflow), 0);

    $display("[TB] enable pause of 7 cycles");
    apply_stimulus(3, 10, 'h5A, 5, 2, 4, 0, 7, 1'b0);
    wait_done();

    $display("[TB] reset during run");
    apply_stimulus(3, 10, 'h5A, 5, 2, 4, 0, 0, 1'b0);
    repeat (12) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    clear_expect();
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_l1a_cnt", int'(l1a_cnt), 0);
    check_output("rst_strobes", int'(lct) + int'(l1a) + int'(alct_dav) + int'(otmb_dav) + int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    apply_stimulus(3, 10, 'h5A, 5, 2, 4, 0, 0, 1'b0);
    wait_done();

    $display("[TB] empty burst");
    apply_stimulus(0, 4, 'hFF, 3, 3, 3, 0, 0, 1'b0);
    wait_done();

    $display("[TB] random bursts");
    for (int i = 0; i < 10; i++) begin
      n  = $urandom_range(0, 7);
      g  = $urandom_range(0, 5);
      a  = $urandom_range(0, 12);
      b  = $urandom_range(0, 12);
      c  = $urandom_range(0, 12);
      ex = (n > 0) && ($urandom_range(0, 1) == 1);
      pa = $urandom_range(0, 10);
      pl = ex ? 0 : $urandom_range(0, 5);
      apply_stimulus(n, g, $urandom_range(1, 255), a, b, c, pa, pl, ex);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
